// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   word_t       32-bit data word
//   lsu_state_t  LSU FSM encoding (IDLE, REQ, WAIT_RSP, DONE)
//   F3_*         funct3 access-size codes
//   is_misaligned() flags H/HU with addr[0]=1 and W with addr[1:0]!=0
package mem_stage_lsu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_REQ      = 2'd1,
    LSU_WAIT_RSP = 2'd2,
    LSU_DONE     = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // f3 must already be normalised (unknown codes mapped to F3_W).
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) mis = off[0];
    else if (f3 == F3_W)           mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/response bus.
//   mem_req/mem_ready : request handshake. The request and all its fields
//     (mem_we, mem_addr, mem_wdata, mem_be) are held stable while mem_req=1
//     and mem_ready=0; the transfer happens in the cycle both are 1.
//   mem_rvalid/mem_rdata : read response, one cycle, no back-pressure.
//   master = LSU side, slave = memory side.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// mem_stage_lsu_load_align: combinational load lane select and extension.
//   rdata  in  raw memory word
//   off    in  byte offset addr[1:0]
//   f3     in  normalised funct3 (B, H, W, BU, HU)
//   data   out selected byte/half, sign- or zero-extended; W passes through
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  word_t       rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output word_t       data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store initiator.
//   clk, rst (async active-low)
//   ALU_Out_4, RD_2_4, Funct3_4, D_RD_4, D_WR_4 : stage-4 command
//   Data_Out_4 : extended load data, valid in DONE, held otherwise
//   Stall_4    : pipeline hold, combinational from the command
//   Misalign_4 : one-cycle misaligned flag (DONE only)
//   state_dbg  : current FSM state
//   mem        : data-memory bus, master side
// Build option: MISALIGN_TRAP_EN -- misaligned H/W accesses skip the bus and
// finish with Misalign_4=1, Data_Out_4=0. Without it the address is forced
// aligned and the access proceeds.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  word_t            ALU_Out_4,
  input  word_t            RD_2_4,
  input  logic [2:0]       Funct3_4,
  input  logic             D_RD_4,
  input  logic             D_WR_4,
  output word_t            Data_Out_4,
  output logic             Stall_4,
  output logic             Misalign_4,
  output lsu_state_t       state_dbg,
  mem_stage_lsu_if.master  mem
);
  lsu_state_t        state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  word_t             wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        f3_q;
  logic              we_q;
  word_t             data_q;
  logic              mis_q;

  logic              cmd;
  logic [2:0]        f3_n;
  logic [ADDR_W-1:0] addr_n;
  word_t             wdata_n;
  logic [3:0]        be_n;
  logic              trap;
  word_t             load_word;

  assign cmd = D_RD_4 | D_WR_4;

  // Normalise funct3, force alignment and build lanes from the incoming command.
  always_comb begin
    f3_n    = F3_W;
    addr_n  = ALU_Out_4[ADDR_W-1:0];
    wdata_n = RD_2_4;
    be_n    = 4'b1111;
    if (Funct3_4 == F3_B || Funct3_4 == F3_BU || Funct3_4 == F3_H || Funct3_4 == F3_HU)
      f3_n = Funct3_4;
    case (f3_n)
      F3_B, F3_BU: begin
        wdata_n = {4{RD_2_4[7:0]}};
        be_n    = 4'b0001 << addr_n[1:0];
      end
      F3_H, F3_HU: begin
        addr_n[0] = 1'b0;
        wdata_n   = {2{RD_2_4[15:0]}};
        be_n      = 4'b0011 << addr_n[1:0];
      end
      default: addr_n[1:0] = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(f3_n, ALU_Out_4[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      LSU_IDLE:     if (cmd) state_nx = trap ? LSU_DONE : LSU_REQ;
      LSU_REQ:      if (mem.mem_ready) state_nx = we_q ? LSU_DONE : LSU_WAIT_RSP;
      LSU_WAIT_RSP: if (mem.mem_rvalid) state_nx = LSU_DONE;
      default:      state_nx = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LSU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_nx;
      // IDLE->DONE happens only on a trap, so this pulse lasts exactly the DONE cycle.
      mis_q <= (state == LSU_IDLE) && cmd && trap;
      if (state == LSU_IDLE && cmd) begin
        addr_q  <= addr_n;
        wdata_q <= wdata_n;
        be_q    <= be_n;
        f3_q    <= f3_n;
        we_q    <= D_WR_4;
        if (trap) data_q <= '0;
      end
      if (state == LSU_WAIT_RSP && mem.mem_rvalid) data_q <= load_word;
    end
  end

  mem_stage_lsu_load_align u_align (
    .rdata (mem.mem_rdata),
    .off   (addr_q[1:0]),
    .f3    (f3_q),
    .data  (load_word)
  );

  assign mem.mem_req   = (state == LSU_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

  // Gated by rst so the stall also drops while reset is held.
  assign Stall_4    = rst && cmd && (state != LSU_DONE);
  assign Data_Out_4 = data_q;
  assign Misalign_4 = mis_q;
  assign state_dbg  = state;
endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  word_t      ALU_Out_4, RD_2_4, Data_Out_4;
  logic [2:0] Funct3_4;
  logic       D_RD_4, D_WR_4, Stall_4, Misalign_4;
  lsu_state_t state_dbg;

  mem_stage_lsu_if #(.ADDR_W(32)) mem_bus ();

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALU_Out_4  (ALU_Out_4),
    .RD_2_4     (RD_2_4),
    .Funct3_4   (Funct3_4),
    .D_RD_4     (D_RD_4),
    .D_WR_4     (D_WR_4),
    .Data_Out_4 (Data_Out_4),
    .Stall_4    (Stall_4),
    .Misalign_4 (Misalign_4),
    .state_dbg  (state_dbg),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          ready_lo, rv_wait;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;   // loads only; stores expect the held value
    int          exp_stall;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [2:0] f3, logic [31:0] rdata, int rlo, int rvw,
                              logic ereq, logic [31:0] eaddr, logic [3:0] ebe,
                              logic [31:0] ewd, logic [31:0] edata, int estall, logic emis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.rdata = rdata;
    v.ready_lo = rlo; v.rv_wait = rvw; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_data = edata; v.exp_stall = estall;
    v.exp_mis = emis;
    return v;
  endfunction

  task automatic idle_bus();
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   stall, req_cnt, wait_cnt, cyc;
    bit   done, seen;
    logic [31:0] exp, got;
    string tag;
    stall = 0; req_cnt = 0; wait_cnt = 0; done = 0; seen = 0;
    tag = $sformatf("v%0d", idx);
    exp = v.exp_mis ? 32'h0 : (v.wr ? last_data : v.exp_data);
    exp_q.push_back(exp);
    last_data = exp;
    @(negedge clk);
    ALU_Out_4 = v.addr; RD_2_4 = v.wdata; Funct3_4 = v.f3;
    D_RD_4 = v.rd; D_WR_4 = v.wr;
    for (cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      idle_bus();
      if (Stall_4) stall++;
      case (state_dbg)
        LSU_REQ: begin
          if (!seen) chk({tag, " req_cycle"}, cyc, 1);
          seen = 1'b1;
          chk({tag, " mem_req"}, {31'h0, mem_bus.mem_req}, 1);
          chk({tag, " mem_addr"}, mem_bus.mem_addr, v.exp_addr);
          chk({tag, " mem_be"}, {28'h0, mem_bus.mem_be}, {28'h0, v.exp_be});
          chk({tag, " mem_we"}, {31'h0, mem_bus.mem_we}, {31'h0, v.wr});
          if (v.wr) chk({tag, " mem_wdata"}, mem_bus.mem_wdata, v.exp_wdata);
          mem_bus.mem_ready = (req_cnt >= v.ready_lo);
          req_cnt++;
        end
        LSU_WAIT_RSP: begin
          mem_bus.mem_rvalid = (wait_cnt >= v.rv_wait);
          mem_bus.mem_rdata  = mem_bus.mem_rvalid ? v.rdata : ~v.rdata;
          wait_cnt++;
        end
        LSU_DONE: begin
          done = 1'b1;
          got = exp_q.pop_front();
          chk({tag, " data_out"}, Data_Out_4, got);
          chk({tag, " misalign"}, {31'h0, Misalign_4}, {31'h0, v.exp_mis});
          chk({tag, " stall_done"}, {31'h0, Stall_4}, 0);
          chk({tag, " stall_cycles"}, stall, v.exp_stall);
          chk({tag, " done_cycle"}, cyc, v.exp_stall);
          chk({tag, " req_seen"}, {31'h0, seen}, {31'h0, v.exp_req});
          D_RD_4 = 1'b0; D_WR_4 = 1'b0;
        end
        default: ;
      endcase
    end
    if (!done) begin
      chk({tag, " timeout"}, 0, 1);
      void'(exp_q.pop_front());
      D_RD_4 = 1'b0; D_WR_4 = 1'b0;
    end
  endtask

  lsu_state_t b2b_exp[6];

  initial begin
    vecs[0]  = mk(0,1,32'h08,32'hDEADBEEF,F3_W, 32'h0,       0,0, 1,32'h08,4'b1111,32'hDEADBEEF,32'h0,       2,0);
    vecs[1]  = mk(1,0,32'h0B,32'h0,       F3_B, 32'h80FF1234,0,0, 1,32'h08,4'b1000,32'h0,       32'hFFFFFF80,3,0);
    vecs[2]  = mk(1,0,32'h0B,32'h0,       F3_BU,32'h80FF1234,0,0, 1,32'h08,4'b1000,32'h0,       32'h00000080,3,0);
    vecs[3]  = mk(1,0,32'h06,32'h0,       F3_H, 32'h9ABC5678,2,3, 1,32'h04,4'b1100,32'h0,       32'hFFFF9ABC,8,0);
    vecs[4]  = mk(0,1,32'h05,32'h000000A5,F3_B, 32'h0,       0,0, 1,32'h04,4'b0010,32'hA5A5A5A5,32'h0,       2,0);
    vecs[5]  = mk(0,1,32'h02,32'h1234BEEF,F3_H, 32'h0,       0,0, 1,32'h00,4'b1100,32'hBEEFBEEF,32'h0,       2,0);
    vecs[6]  = mk(1,0,32'h02,32'h0,       F3_HU,32'h80017FFF,0,0, 1,32'h00,4'b1100,32'h0,       32'h00008001,3,0);
    vecs[7]  = mk(1,0,32'h10,32'h0,       F3_W, 32'h12345678,1,1, 1,32'h10,4'b1111,32'h0,       32'h12345678,5,0);
`ifdef MISALIGN_TRAP_EN
    vecs[8]  = mk(1,0,32'h06,32'h0,       F3_W, 32'hCAFEF00D,0,0, 0,32'h0, 4'b0000,32'h0,       32'h0,       1,1);
`else
    vecs[8]  = mk(1,0,32'h06,32'h0,       F3_W, 32'hCAFEF00D,0,0, 1,32'h04,4'b1111,32'h0,       32'hCAFEF00D,3,0);
`endif
    vecs[9]  = mk(1,0,32'h0C,32'h0,       3'b011,32'h0BADF00D,0,0,1,32'h0C,4'b1111,32'h0,       32'h0BADF00D,3,0);
    vecs[10] = mk(1,1,32'h14,32'h55AA55AA,F3_W, 32'h0,       0,0, 1,32'h14,4'b1111,32'h55AA55AA,32'h0,       2,0);
`ifdef MISALIGN_TRAP_EN
    vecs[11] = mk(1,0,32'h01,32'h0,       F3_H, 32'h11118765,0,0, 0,32'h0, 4'b0000,32'h0,       32'h0,       1,1);
`else
    vecs[11] = mk(1,0,32'h01,32'h0,       F3_H, 32'h11118765,0,0, 1,32'h00,4'b0011,32'h0,       32'hFFFF8765,3,0);
`endif
    vecs[12] = mk(1,0,32'h01,32'h0,       F3_B, 32'h00007F00,0,0, 1,32'h00,4'b0010,32'h0,       32'h0000007F,3,0);

    b2b_exp = '{LSU_IDLE, LSU_REQ, LSU_DONE, LSU_IDLE, LSU_REQ, LSU_DONE};

    // Reset state
    rst = 1'b0; ALU_Out_4 = '0; RD_2_4 = '0; Funct3_4 = '0; D_RD_4 = 0; D_WR_4 = 0;
    idle_bus();
    repeat (2) @(negedge clk);
    #1;
    chk("rst data_out", Data_Out_4, 0);
    chk("rst mem_req", {31'h0, mem_bus.mem_req}, 0);
    chk("rst stall", {31'h0, Stall_4}, 0);
    chk("rst misalign", {31'h0, Misalign_4}, 0);
    chk("rst state", {30'h0, state_dbg}, {30'h0, LSU_IDLE});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Back-to-back stores with the command held: one IDLE cycle between accesses.
    @(negedge clk);
    ALU_Out_4 = 32'h20; RD_2_4 = 32'h0F0F0F0F; Funct3_4 = F3_W; D_WR_4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      mem_bus.mem_ready = 1'b1;
      chk($sformatf("b2b state c%0d", c), {30'h0, state_dbg}, {30'h0, b2b_exp[c]});
      if (c == 5) D_WR_4 = 1'b0;
    end
    mem_bus.mem_ready = 1'b0;
    chk("b2b data_hold", Data_Out_4, last_data);

    // Stray rvalid while idle is ignored.
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h13572468;
    @(negedge clk);
    #1;
    idle_bus();
    chk("stray rvalid state", {30'h0, state_dbg}, {30'h0, LSU_IDLE});
    chk("stray rvalid data", Data_Out_4, last_data);

    // Reset during WAIT_RSP.
    @(negedge clk);
    ALU_Out_4 = 32'h30; Funct3_4 = F3_W; D_RD_4 = 1'b1;
    begin
      int n;
      n = 0;
      #1;
      while (state_dbg != LSU_WAIT_RSP && n < 10) begin
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n++;
      end
      mem_bus.mem_ready = 1'b0;
      chk("rstmid reached_wait", {30'h0, state_dbg}, {30'h0, LSU_WAIT_RSP});
    end
    rst = 1'b0;
    #1;
    chk("rstmid mem_req", {31'h0, mem_bus.mem_req}, 0);
    chk("rstmid stall", {31'h0, Stall_4}, 0);
    chk("rstmid data_out", Data_Out_4, 0);
    chk("rstmid state", {30'h0, state_dbg}, {30'h0, LSU_IDLE});
    D_RD_4 = 1'b0;
    last_data = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    idle_bus();
    chk("late rvalid state", {30'h0, state_dbg}, {30'h0, LSU_IDLE});
    chk("late rvalid data", Data_Out_4, 0);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store initiator for the MEM stage of the 5-stage pipeline. It takes the stage-4 load/store command (effective address, store data, funct3), drives a valid/ready request to the data memory, and waits for the read response. It returns aligned, sign- or zero-extended load data to writeback and stalls the pipeline for the duration of the access. It is the requesting end of the data memory interface, so the memory can have variable latency.

## Interface
Parameters:
- ADDR_W, 32, width of mem_addr (byte address)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ALU_Out_4  in  32 (word_t)  effective byte address
- RD_2_4  in  32 (word_t)  store source register
- Funct3_4  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- D_RD_4  in  1  load command present
- D_WR_4  in  1  store command present
- Data_Out_4  out  32 (word_t)  extended load data, valid in DONE
- Stall_4  out  1  hold IF–MEM stages
- Misalign_4  out  1  one-cycle misaligned-access flag
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: if D_RD_4 or D_WR_4, latch address, data, funct3 and direction, then go to REQ. If both are high, the store wins.
- REQ: mem_req=1 with latched fields, held stable until mem_ready. When ready: a store goes to DONE; a load goes to WAIT_RSP.
- WAIT_RSP: on mem_rvalid, capture mem_rdata and go to DONE. mem_rvalid outside WAIT_RSP is ignored.
- DONE: Data_Out_4 is valid and Stall_4=0. Always returns to IDLE.
- Stall_4 = (D_RD_4|D_WR_4) && state!=DONE. This is combinational, so the stall is raised in the same cycle the command appears.
- Store lanes:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011<<addr[1:0].
  - SW: be=1111.
- Load: select byte/half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- Any other funct3 value is treated as W.
- Data_Out_4 holds its last value outside DONE. Misalign_4 is asserted only in DONE.
- Reset: all outputs 0 and state IDLE. Reset mid-transaction abandons the access immediately; mem_req drops asynchronously and a late mem_rvalid after release is ignored.

## Timing
- Store, zero wait: cycle 0 command → cycle 1 REQ accepted → cycle 2 DONE. Stall_4 is high in cycles 0–1.
- Load, zero wait (rvalid is earliest the cycle after accept): 0 IDLE, 1 REQ, 2 WAIT_RSP+rvalid, 3 DONE. Minimum stall is 3 cycles.
- Each cycle of mem_ready low or mem_rvalid late adds one cycle.
- Back-to-back commands: DONE→IDLE→REQ, so there is one IDLE cycle between accesses.
- Only one outstanding request at a time.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned access is H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - It skips REQ (no mem_req) and goes IDLE→DONE.
  - Misalign_4=1 and Data_Out_4=0 in DONE.
- Undefined:
  - Misalign_4 is tied 0.
  - The address is forced aligned (H clears bit 0, W clears bits 1:0) and the access proceeds normally.

## Structure
- RISCV_pkg additions: lsu_state_t enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- word_t is reused from RISCV_pkg.
- One sub-module, lsu_load_align: a combinational lane select and extend (mem_rdata, addr[1:0], funct3 → word).

## Test plan
- SW addr 0x08, RD_2_4=0xDEADBEEF, mem_ready=1:
  - mem_addr=0x08, be=1111, wdata=0xDEADBEEF in cycle 1.
  - Stall_4 high in cycles 0–1, low in cycle 2.
- LB addr 0x0B, mem_rdata=0x80FF1234 → Data_Out_4=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr 0x06, mem_rdata=0x9ABC5678:
  - mem_ready low for 2 cycles, mem_rvalid 3 cycles after accept.
  - mem_req is held stable; Data_Out_4=0xFFFF9ABC; total stall 8 cycles.
- SB addr 0x05, data 0x000000A5 → be=0010, wdata=0xA5A5A5A5.
- LW addr 0x06:
  - With MISALIGN_TRAP_EN: no mem_req, Misalign_4=1 in cycle 1.
  - Without: mem_addr=0x04 and a normal load.
- rst low during WAIT_RSP:
  - mem_req, Stall_4 and Data_Out_4 go to 0 immediately.
  - A later mem_rvalid after release leaves state IDLE.
